// File: rtl/gc_poll_engine.sv
// gc_poll_engine: GameCube poll engine, sends the 24-bit poll command and captures the 64-bit reply.
// Define GC_POLL_GLITCH_FILTER_EN to add a 3-sample majority filter after the input synchroniser.
module gc_poll_engine #(
    parameter int US_TICKS   = 10,
    parameter int TIMEOUT_US = 100,
    parameter int GAP_US     = 8
) (
    input  logic        SYSCLK,
    input  logic        SYSRESET,
    input  logic        start,
    input  logic        rumble,
    input  logic        data_in,
    output logic        data_oe,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [63:0] resp
);
    localparam int CW = $clog2((TIMEOUT_US + GAP_US + 4) * US_TICKS);
    localparam logic [CW-1:0] BIT_END  = CW'(4 * US_TICKS - 1);
    localparam logic [CW-1:0] ONE_END  = CW'(US_TICKS - 1);
    localparam logic [CW-1:0] LOW1     = CW'(US_TICKS);
    localparam logic [CW-1:0] LOW0     = CW'(3 * US_TICKS);
    localparam logic [CW-1:0] SAMP_END = CW'(2 * US_TICKS - 1);
    localparam logic [CW-1:0] TMO_END  = CW'(TIMEOUT_US * US_TICKS - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(GAP_US * US_TICKS - 1);

    typedef enum logic [2:0] {IDLE, TX_BIT, TX_STOP, RX_WAIT, RX_BIT, FINISH} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [5:0]    idx;
    logic [23:0]   tx_shift;
    logic [62:0]   rx_shift;
    logic          ok;
    logic [1:0]    sync;
    logic          line, line_d, fall;

    always_ff @(posedge SYSCLK or posedge SYSRESET) begin
        if (SYSRESET) begin
            sync   <= 2'b11;
            line_d <= 1'b1;
        end else begin
            sync   <= {sync[0], data_in};
            line_d <= line;
        end
    end

`ifdef GC_POLL_GLITCH_FILTER_EN
    logic [2:0] hist;
    logic       filt;

    always_ff @(posedge SYSCLK or posedge SYSRESET) begin
        if (SYSRESET) begin
            hist <= 3'b111;
            filt <= 1'b1;
        end else begin
            hist <= {hist[1:0], sync[1]};
            filt <= (hist[0] & hist[1]) | (hist[1] & hist[2]) | (hist[0] & hist[2]);
        end
    end

    assign line = filt;
`else
    assign line = sync[1];
`endif

    assign fall = line_d & ~line;

    always_ff @(posedge SYSCLK or posedge SYSRESET) begin
        if (SYSRESET) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        data_oe = 1'b0;
        case (state)
            IDLE: state_n = start ? TX_BIT : IDLE;
            TX_BIT: begin
                data_oe = cnt < (tx_shift[23] ? LOW1 : LOW0);
                if (cnt == BIT_END && idx == 6'd23) state_n = TX_STOP;
            end
            TX_STOP: begin
                data_oe = 1'b1;
                if (cnt == ONE_END) state_n = RX_WAIT;
            end
            // First reply edge gets the long window, later edges the short gap window
            RX_WAIT: begin
                if (fall)                                          state_n = RX_BIT;
                else if (cnt == (idx == 6'd0 ? TMO_END : GAP_END)) state_n = FINISH;
            end
            RX_BIT:  if (cnt == SAMP_END) state_n = idx == 6'd63 ? FINISH : RX_WAIT;
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign busy    = state != IDLE && state != FINISH;
    assign done    = state == FINISH && ok;
    assign timeout = state == FINISH && !ok;

    // cnt keeps running from the detected edge through RX_WAIT, so the gap window is edge-relative
    always_ff @(posedge SYSCLK or posedge SYSRESET) begin
        if (SYSRESET) begin
            cnt      <= '0;
            idx      <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            ok       <= 1'b0;
            resp     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    ok  <= 1'b0;
                    if (start) tx_shift <= {16'h4003, 7'b0, rumble};
                end
                TX_BIT: begin
                    if (cnt == BIT_END) begin
                        cnt      <= '0;
                        idx      <= (idx == 6'd23) ? 6'd0 : idx + 6'd1;
                        tx_shift <= tx_shift << 1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TX_STOP: cnt <= (cnt == ONE_END) ? '0 : cnt + 1'b1;
                RX_WAIT: cnt <= fall ? '0 : cnt + 1'b1;
                RX_BIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == SAMP_END) begin
                        rx_shift <= {rx_shift[61:0], line};
                        idx      <= idx + 6'd1;
                        if (idx == 6'd63) begin
                            resp <= {rx_shift, line};
                            ok   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_gc_poll_engine.sv
// tb_gc_poll_engine: randomized polls against a controller model, scoreboard monitor checks TX waveform and results.
module tb_gc_poll_engine;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, rumble = 1'b0, ctrl = 1'b1;
    logic        data_oe, busy, done, timeout, data_in;
    logic [63:0] resp;

    assign data_in = data_oe ? 1'b0 : ctrl;
    always #5 clk = ~clk;

    gc_poll_engine dut (
        .SYSCLK(clk), .SYSRESET(rst), .start(start), .rumble(rumble), .data_in(data_in),
        .data_oe(data_oe), .busy(busy), .done(done), .timeout(timeout), .resp(resp)
    );

    typedef struct {
        bit          d;
        logic [63:0] resp;
        int          lo;
        int          hi;
        bit          from_edge;
    } exp_t;

    exp_t        sbq[$];
    logic [23:0] txq[$];
    logic [63:0] last_resp = '0;
    int          total = 0, bad = 0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h", n, a, e);
        end
    endtask

    task automatic chk_rng(input string n, input int a, input int lo, input int hi);
        total++;
        if (a < lo || a > hi) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d..%0d", n, a, lo, hi);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Low time of pulse k of a poll: 24 command bits MSB first, then the 1 us stop bit
    function automatic int low_of(input logic [23:0] cmd, input int k);
        return (k >= 24) ? 10 : (cmd[23-k] ? 10 : 30);
    endfunction

    task automatic monitor();
        logic        oe_prev = 1'b0, ctrl_prev = 1'b1, in_tx = 1'b0;
        logic [23:0] cmd = '0;
        int          k = 0, run = 0, tx_len = 0, since_rel = 0, since_edge = 0;
        exp_t        e;
        forever begin
            @(negedge clk);
            since_rel++;
            since_edge++;
            if (ctrl_prev && !ctrl) since_edge = 0;
            ctrl_prev = ctrl;
            if (rst) begin
                in_tx   = 1'b0;
                oe_prev = 1'b0;
                run     = 0;
            end else begin
                if (data_oe && !oe_prev) begin
                    if (in_tx) chk($sformatf("tx_high%0d", k - 1), 64'(run), 64'(40 - low_of(cmd, k - 1)));
                    else if (txq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL tx_unexpected data_oe=1 want 0");
                    end else begin
                        cmd    = txq.pop_front();
                        in_tx  = 1'b1;
                        k      = 0;
                        tx_len = 0;
                        chk("busy_at_tx", 64'(busy), 64'd1);
                    end
                    run = 0;
                end else if (!data_oe && oe_prev && in_tx) begin
                    chk($sformatf("tx_low%0d", k), 64'(run), 64'(low_of(cmd, k)));
                    if (k == 24) begin
                        chk("tx_len", 64'(tx_len), 64'd970);
                        in_tx     = 1'b0;
                        since_rel = 0;
                    end
                    k++;
                    run = 0;
                end
                oe_prev = data_oe;
                run++;
                tx_len++;
                if (done || timeout) begin
                    if (sbq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL result_unexpected done=%0b timeout=%0b want none", done, timeout);
                    end else begin
                        e = sbq.pop_front();
                        chk("result_kind", {62'd0, done, timeout}, e.d ? 64'd2 : 64'd1);
                        chk("resp", resp, e.resp);
                        chk("busy_at_end", 64'(busy), 64'd0);
                        if (e.lo >= 0)
                            chk_rng(e.from_edge ? "timeout_gap" : "timeout_first",
                                    e.from_edge ? since_edge : since_rel, e.lo, e.hi);
                    end
                end
            end
        end
    endtask

    task automatic poll(input logic r, input logic [63:0] reply, input int nbits,
                        input int rst_at, input bit poke, input bit glitch);
        int quiet, n;
        txq.push_back({16'h4003, 7'b0, r});
        if (rst_at < 0) begin
            if (nbits == 64) begin
                sbq.push_back('{1'b1, reply, -1, -1, 1'b0});
                last_resp = reply;
            end else if (nbits == 0) sbq.push_back('{1'b0, last_resp, 1000, 1000, 1'b0});
            else                     sbq.push_back('{1'b0, last_resp, 80, 86, 1'b1});
        end
        start  = 1'b1;
        rumble = r;
        cyc();
        start  = 1'b0;
        rumble = 1'($urandom);
        quiet  = 0;
        n      = 0;
        while (quiet < 35 && n < 1200) begin
            cyc();
            n++;
            quiet = data_oe ? 0 : quiet + 1;
        end
        repeat ($urandom_range(5, 150)) cyc();
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < 40; c++) begin
                if (b == rst_at && c == 0) begin
                    #2 rst = 1'b1;
                    #1;
                    chk("rst_oe", 64'(data_oe), 64'd0);
                    chk("rst_busy", 64'(busy), 64'd0);
                    chk("rst_resp", resp, 64'd0);
                    last_resp = '0;
                    ctrl      = 1'b1;
                    repeat (5) cyc();
                    rst = 1'b0;
                    repeat (3) cyc();
                    return;
                end
                ctrl  = (c < (reply[63-b] ? 10 : 30)) ? 1'b0 : 1'b1;
                if (glitch && c == 35) ctrl = 1'b0;
                start = poke && c == 0;
                cyc();
            end
        end
        start = 1'b0;
        if (nbits == 64) begin
            ctrl = 1'b0;
            repeat (10) cyc();
        end
        ctrl = 1'b1;
        n    = 0;
        while (busy && n < 4000) begin
            cyc();
            n++;
        end
        chk("busy_drop", 64'(busy), 64'd0);
        repeat (3) cyc();
    endtask

    initial begin
        int          oe_cnt;
        int          nb;
        logic [63:0] w;
        fork
            monitor();
        join_none
        repeat (10) cyc();
        chk("reset_oe", 64'(data_oe), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_timeout", 64'(timeout), 64'd0);
        chk("reset_resp", resp, 64'd0);
        rst    = 1'b0;
        oe_cnt = 0;
        repeat (100) begin
            cyc();
            oe_cnt += int'(data_oe);
        end
        chk("idle_oe_cycles", 64'(oe_cnt), 64'd0);

        poll(1'b0, 64'd0, 0, -1, 1'b0, 1'b0);
        poll(1'b1, 64'd0, 0, -1, 1'b0, 1'b0);
        poll(1'b0, 64'h0080_8080_8080_0000, 64, -1, 1'b0, 1'b0);
        poll(1'b1, 64'hFFFF_0000_1234_ABCD, 64, -1, 1'b0, 1'b0);
        poll(1'b0, 64'd0, 0, -1, 1'b0, 1'b0);
        poll(1'($urandom), {$urandom(), $urandom()}, 20, -1, 1'b1, 1'b0);
        poll(1'b0, {$urandom(), $urandom()}, 64, 30, 1'b0, 1'b0);
        poll(1'b1, {$urandom(), $urandom()}, 64, -1, 1'b0, 1'b0);
`ifdef GC_POLL_GLITCH_FILTER_EN
        poll(1'b0, {$urandom(), $urandom()}, 64, -1, 1'b0, 1'b1);
`endif
        repeat (6) begin
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 63)) : 64;
            w  = {$urandom(), $urandom()};
            poll(1'($urandom), w, nb, -1, 1'($urandom), 1'b0);
        end
        repeat (20) cyc();
        chk("scoreboard_left", 64'(sbq.size()), 64'd0);
        chk("tx_left", 64'(txq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
